// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encodings and the default drain length.
package pipeline_ctrl_pkg;

   localparam int DRAIN_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic is_active(input state_e s);
      return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline run/step/drain sequencer driving the stage write enables.
// Optional cycle counter output: PIPELINE_SEQ_CTRL_CYCLE_CNT_EN.
module pipeline_seq_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dbg_run,
   input  logic        dbg_step,
   input  logic        dbg_halt,
   input  logic        halt_id,
   input  logic        hz_stall,
   input  logic        hz_jflush,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_we,
   output logic        exmem_we,
   output logic        memwb_we,
   output logic        ctrl_bubble,
   output logic [2:0]  state,
`ifdef PIPELINE_SEQ_CTRL_CYCLE_CNT_EN
   output logic [31:0] cycle_cnt,
`endif
   output logic        done
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ctrl_bubble = 1'b0;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dbg_step) begin
               state_d = ST_STEP;
            end else if (dbg_run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_STEP: begin
            idex_we     = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            pc_we       = !hz_stall && !halt_id;
            ifid_we     = !hz_stall && !hz_jflush && !halt_id;
            ctrl_bubble = hz_stall || halt_id;
            // HALT outranks a debug halt; a step always ends after one cycle
            if (halt_id) begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_LOAD;
            end else if (state_q == ST_STEP || dbg_halt) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            idex_we     = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            ctrl_bubble = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign state = state_q;

`ifdef PIPELINE_SEQ_CTRL_CYCLE_CNT_EN
   logic [31:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (is_active(state_q) && (cyc_q != 32'hFFFF_FFFF)) begin
         cyc_d = cyc_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cycle_cnt = cyc_q;
`endif

endmodule

// File: doc/pipeline_seq_ctrl.md
PIPELINE_SEQ_CTRL -- requirements
Module: pipeline_seq_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 4, cycles the pipeline keeps running after HALT is decoded, so older instructions retire.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 dbg_run  input  1  one-cycle pulse from debug unit: free-run.
REQ-005 dbg_step  input  1  one-cycle pulse: advance pipeline exactly one cycle.
REQ-006 dbg_halt  input  1  one-cycle pulse: pause pipeline.
REQ-007 halt_id  input  1  HALT opcode decoded in ID stage.
REQ-008 hz_stall  input  1  load-use stall request from hazard unit.
REQ-009 hz_jflush  input  1  jump in ID: PC advances, IF/ID holds.
REQ-010 pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  stage write enables.
REQ-011 ctrl_bubble  output  1  zero ID/EX control signals this cycle.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 done  output  1  program ended and pipeline drained.

Function
REQ-014 States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4; encodings 5-7 SHALL go to IDLE next cycle.
REQ-015 Transition priority per cycle: halt_id > dbg_halt > dbg_step > dbg_run.
REQ-016 IDLE: dbg_step -> STEP; dbg_run -> RUN; else stay.
REQ-017 RUN: halt_id -> DRAIN; dbg_halt -> IDLE; dbg_step, dbg_run ignored.
REQ-018 STEP: lasts exactly one cycle; halt_id -> DRAIN, else -> IDLE.
REQ-019 DRAIN: load down-counter with DRAIN_CYCLES-1 on entry; decrement each cycle; at 0 -> DONE; all debug pulses ignored.
REQ-020 DONE: terminal; only rst_n exits; done=1 only in DONE.
REQ-021 Outputs are combinational from state and inputs (zero latency).
REQ-022 IDLE, DONE: all enables 0, ctrl_bubble 0.
REQ-023 RUN/STEP: idex_we=exmem_we=memwb_we=1; pc_we = !hz_stall && !halt_id; ifid_we = !hz_stall && !hz_jflush && !halt_id; ctrl_bubble = hz_stall || halt_id.
REQ-024 DRAIN: pc_we=ifid_we=0; idex/exmem/memwb_we=1; ctrl_bubble=1; hz_stall, hz_jflush ignored.
REQ-025 hz_stall during STEP consumes the step: that cycle is a bubble, pc_we=0, returns to IDLE.
REQ-026 dbg_halt and halt_id in the same RUN cycle: DRAIN wins.
REQ-027 DRAIN_CYCLES=1: DRAIN lasts one cycle, then DONE.

Reset
REQ-028 rst_n low: state=IDLE, drain counter=0, cycle counter=0, all enables 0, ctrl_bubble 0, done 0, immediately and asynchronously, including mid-DRAIN or mid-STEP.
REQ-029 First state change no earlier than first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro PIPELINE_SEQ_CTRL_CYCLE_CNT_EN: defined -> extra output cycle_cnt (32-bit), increments each cycle in RUN, STEP or DRAIN, saturates at 0xFFFFFFFF, holds in IDLE/DONE; undefined -> port and counter absent, other behaviour identical.

Structure
REQ-031 Shared package pipeline_ctrl_pkg holds state encodings and DRAIN_CYCLES default; hazard and debug units import it.
REQ-032 No sub-module; FSM, drain counter and optional cycle counter are inline.

Verification
REQ-033 Reset, dbg_run pulse -> state 0->1 next edge; all five enables 1; done 0.
REQ-034 RUN, hz_stall=1 one cycle -> pc_we=0, ifid_we=0, ctrl_bubble=1, idex_we=1; next cycle pc_we=1.
REQ-035 IDLE, three dbg_step pulses 2 cycles apart -> exactly 3 cycles with pc_we=1; state back to 0 after each.
REQ-036 RUN, halt_id=1 -> state 3 for 4 cycles with pc_we=0 and memwb_we=1, then state 4, done=1, enables 0; dbg_run now ignored.
REQ-037 RUN, dbg_halt and halt_id same cycle -> DRAIN; rst_n low during DRAIN cycle 2 -> state 0, enables 0 with no clock edge.
REQ-038 With macro: reset, dbg_run, run 10 cycles, dbg_halt -> cycle_cnt=11 and holds in IDLE.
